// File: rtl/rc4_pkg.sv
// Shared state encoding, default sizes and key-byte helper for the RC4 KSA engine.
package rc4_pkg;

    localparam int DEFAULT_ADDR_W    = 8;
    localparam int DEFAULT_KEY_BYTES = 3;
    localparam int MAX_KEY_BITS      = 256;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        RD_I,
        CALC_J,
        RD_J,
        CAP_J,
        WR_I,
        WR_J,
        DONE
    } state_e;

    // Byte 0 is the most significant byte of an nBytes-long key.
    function automatic logic [7:0] keyByte(input logic [MAX_KEY_BITS-1:0] keyWide,
                                           input int unsigned idx,
                                           input int unsigned nBytes);
        return 8'(keyWide >> (8 * (nBytes - 1 - idx)));
    endfunction

endpackage

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine driving an external single-port synchronous S-box RAM.
// Optionally fills S with the identity first, then performs the KSA swap loop.
module rc4_ksa_engine
    import rc4_pkg::*;
#(
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int KEY_BYTES = DEFAULT_KEY_BYTES
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   do_init,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [ADDR_W-1:0]      mem_wdata,
    output logic                   mem_wren,
    input  logic [ADDR_W-1:0]      mem_q,
    output logic                   busy,
    output logic                   done
);

    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [ADDR_W-1:0] I_MAX = '1;
    localparam logic [KW-1:0]     K_MAX = KW'(KEY_BYTES - 1);

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        i_q, i_d;
    logic [ADDR_W-1:0]        j_q, j_d;
    logic [KW-1:0]            k_q, k_d;
    logic [ADDR_W-1:0]        si_q, si_d;
    logic [ADDR_W-1:0]        sj_q, sj_d;
    logic [8*KEY_BYTES-1:0]   key_q, key_d;
    logic [7:0]               curKeyByte;

    assign curKeyByte = keyByte(MAX_KEY_BITS'(key_q), 32'(k_q), KEY_BYTES);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            key_q   <= key_d;
        end
    end

    // Each KSA step is read S[i], update j, read S[j], then write both back.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        si_d      = si_q;
        sj_d      = sj_q;
        key_d     = key_q;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    state_d = do_init ? INIT : RD_I;
                end
            end
            INIT: begin
                busy      = 1'b1;
                mem_addr  = i_q;
                mem_wdata = i_q;
                mem_wren  = 1'b1;
                if (i_q == I_MAX) begin
                    i_d     = '0;
                    state_d = RD_I;
                end else begin
                    i_d = i_q + ADDR_W'(1);
                end
            end
            RD_I: begin
                busy     = 1'b1;
                mem_addr = i_q;
                state_d  = CALC_J;
            end
            CALC_J: begin
                busy     = 1'b1;
                mem_addr = i_q;
                si_d     = mem_q;
                j_d      = j_q + mem_q + ADDR_W'(curKeyByte);
                state_d  = RD_J;
            end
            RD_J: begin
                busy     = 1'b1;
                mem_addr = j_q;
                state_d  = CAP_J;
            end
            CAP_J: begin
                busy     = 1'b1;
                mem_addr = j_q;
                sj_d     = mem_q;
                state_d  = WR_I;
            end
            WR_I: begin
                busy      = 1'b1;
                mem_addr  = i_q;
                mem_wdata = sj_q;
                mem_wren  = 1'b1;
                state_d   = WR_J;
            end
            WR_J: begin
                busy      = 1'b1;
                mem_addr  = j_q;
                mem_wdata = si_q;
                mem_wren  = 1'b1;
                if (i_q == I_MAX) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + ADDR_W'(1);
                    k_d     = (k_q == K_MAX) ? '0 : k_q + KW'(1);
                    state_d = RD_I;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Randomised self-checking bench for rc4_ksa_engine: three configurations against a software RC4 KSA model.
module tb_rc4_ksa_engine;

    logic        clk;
    logic        reset_n;
    logic        startV   [3];
    logic        doInitV  [3];
    logic [23:0] keyV     [3];
    logic [7:0]  addrV    [3];
    logic [7:0]  wdataV   [3];
    logic        wrenV    [3];
    logic [7:0]  qV       [3];
    logic        busyV    [3];
    logic        doneV    [3];
    logic        loadReq  [3];

    logic [7:0]  ram [3][256];
    int          preImg [256];
    int          refS   [256];
    int          total;
    int          bad;

    logic [1:0]  addr0, wdata0, addr1, wdata1;
    logic [7:0]  addr2, wdata2;

    assign addrV[0]  = {6'd0, addr0};
    assign wdataV[0] = {6'd0, wdata0};
    assign addrV[1]  = {6'd0, addr1};
    assign wdataV[1] = {6'd0, wdata1};
    assign addrV[2]  = addr2;
    assign wdataV[2] = wdata2;

    rc4_ksa_engine #(.ADDR_W(2), .KEY_BYTES(1)) dutSmall1 (
        .clk(clk), .reset_n(reset_n), .start(startV[0]), .do_init(doInitV[0]),
        .key(keyV[0][7:0]), .mem_addr(addr0), .mem_wdata(wdata0), .mem_wren(wrenV[0]),
        .mem_q(qV[0][1:0]), .busy(busyV[0]), .done(doneV[0])
    );

    rc4_ksa_engine #(.ADDR_W(2), .KEY_BYTES(3)) dutSmall3 (
        .clk(clk), .reset_n(reset_n), .start(startV[1]), .do_init(doInitV[1]),
        .key(keyV[1]), .mem_addr(addr1), .mem_wdata(wdata1), .mem_wren(wrenV[1]),
        .mem_q(qV[1][1:0]), .busy(busyV[1]), .done(doneV[1])
    );

    rc4_ksa_engine #(.ADDR_W(8), .KEY_BYTES(3)) dutBig (
        .clk(clk), .reset_n(reset_n), .start(startV[2]), .do_init(doInitV[2]),
        .key(keyV[2]), .mem_addr(addr2), .mem_wdata(wdata2), .mem_wren(wrenV[2]),
        .mem_q(qV[2]), .busy(busyV[2]), .done(doneV[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAMs with registered read data; loadReq bulk-copies preImg.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (loadReq[d]) begin
                for (int a = 0; a < 256; a++) ram[d][a] <= 8'(preImg[a]);
            end else if (wrenV[d]) begin
                ram[d][addrV[d]] <= wdataV[d];
            end
            qV[d] <= ram[d][addrV[d]];
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int d, input logic [23:0] k, input bit init);
        startV[d]  = 1'b1;
        keyV[d]    = k;
        doInitV[d] = init;
    endtask

    task automatic randomPre(input int n);
        for (int a = 0; a < 256; a++) preImg[a] = (a < n) ? int'($urandom_range(n - 1, 0)) : 0;
    endtask

    // Textbook KSA on refS: j = (j + S[i] + key[i mod kb]) mod n, then swap.
    task automatic refKsa(input int n, input int kb, input logic [23:0] k);
        int j;
        int t;
        int kByte;
        j = 0;
        for (int i = 0; i < n; i++) begin
            kByte   = int'((k >> (8 * (kb - 1 - (i % kb)))) & 24'hFF);
            j       = (j + refS[i] + kByte) % n;
            t       = refS[i];
            refS[i] = refS[j];
            refS[j] = t;
        end
    endtask

    task automatic runCase(input int d, input int n, input int kb, input logic [23:0] k,
                           input bit init, input bit poke, input int resetAt);
        int expLat;
        int doneAt;
        int doneCnt;
        int busyCnt;
        bit aborted;
        expLat  = 1 + (init ? n : 0) + 6 * n;
        doneAt  = 0;
        doneCnt = 0;
        busyCnt = 0;
        aborted = 0;
        if (init) randomPre(n);
        for (int a = 0; a < 256; a++) refS[a] = init ? a : preImg[a];
        refKsa(n, kb, k);

        @(negedge clk);
        loadReq[d] = 1'b1;
        @(negedge clk);
        loadReq[d] = 1'b0;
        applyStimulus(d, k, init);

        for (int c = 1; c <= expLat + 20; c++) begin
            @(negedge clk);
            if (resetAt != 0 && c == resetAt + 1) begin
                checkOutput("busyAfterReset", int'(busyV[d]), 0);
                checkOutput("doneAfterReset", int'(doneV[d]), 0);
                checkOutput("wrenAfterReset", int'(wrenV[d]), 0);
                checkOutput("addrAfterReset", int'(addrV[d]), 0);
                reset_n = 1'b1;
                aborted = 1;
                break;
            end
            if (c == 1) checkOutput("busyAfterStart", int'(busyV[d]), 1);
            if (busyV[d]) busyCnt++;
            if (doneV[d]) begin
                doneCnt++;
                if (doneAt == 0) doneAt = c;
            end
            if (c == 1) begin
                startV[d]  = 1'b0;
                keyV[d]    = 24'($urandom);
                doInitV[d] = ~init;
            end
            if (poke && c == 100) startV[d] = 1'b1;
            if (poke && c == 101) startV[d] = 1'b0;
            if (resetAt != 0 && c == resetAt) reset_n = 1'b0;
            if (doneAt != 0 && c >= doneAt + 2) break;
        end
        startV[d] = 1'b0;
        if (aborted) begin
            @(negedge clk);
            return;
        end

        checkOutput($sformatf("latency[d%0d]", d), doneAt, expLat);
        checkOutput($sformatf("doneCount[d%0d]", d), doneCnt, 1);
        checkOutput($sformatf("busyCycles[d%0d]", d), busyCnt, expLat - 1);
        for (int a = 0; a < n; a++)
            checkOutput($sformatf("ram%0d[%0d]", d, a), int'(ram[d][a]), refS[a]);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            startV[d]  = 1'b0;
            doInitV[d] = 1'b0;
            keyV[d]    = '0;
            loadReq[d] = 1'b0;
        end
        for (int a = 0; a < 256; a++) preImg[a] = 0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checkOutput("resetBusy", int'(busyV[d]), 0);
            checkOutput("resetDone", int'(doneV[d]), 0);
            checkOutput("resetWren", int'(wrenV[d]), 0);
            checkOutput("resetAddr", int'(addrV[d]), 0);
            checkOutput("resetWdata", int'(wdataV[d]), 0);
        end
        reset_n = 1'b1;

        runCase(0, 4, 1, 24'h000001, 1, 0, 0);
        runCase(0, 4, 1, 24'h000000, 1, 0, 0);
        runCase(1, 4, 3, 24'h010203, 1, 0, 0);

        runCase(2, 256, 3, 24'h000000, 1, 0, 0);
        for (int a = 0; a < 256; a++) preImg[a] = a;
        runCase(2, 256, 3, 24'h000000, 0, 0, 0);

        runCase(2, 256, 3, 24'($urandom), 1, 1, 0);
        randomPre(256);
        runCase(2, 256, 3, 24'($urandom), 0, 0, 0);
        runCase(2, 256, 3, 24'($urandom), 1, 0, 500);
        runCase(2, 256, 3, 24'($urandom), 1, 0, 0);

        for (int r = 0; r < 6; r++) begin
            for (int d = 0; d < 2; d++) begin
                bit init;
                init = 1'($urandom_range(1, 0));
                if (!init) randomPre(4);
                runCase(d, 4, (d == 0) ? 1 : 3, 24'($urandom), init, 0, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
